sfp_acc_array: RTL

Parametrised successor to the per-column SFP stage that sits after the OFIFO in the corelet. It accumulates column psums over a runtime-programmable number of passes into an on-chip bank of DEPTH entries. It then drains the results with optional ReLU and signed saturation over a valid/ready handshake. It replaces the single-register accumulate of the current SFP with multi-entry, multi-pass, flow-controlled accumulation.

---
 rtl/sfp_acc_array_pkg.sv | 32 +++
 rtl/sfp_acc_array_if.sv | 30 +++
 rtl/sfp_acc_array_post.sv | 48 ++++
 rtl/sfp_acc_array.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sfp_acc_array_pkg.sv
// rtl/sfp_acc_array_pkg.sv - shared types and width/bound helpers for the SFP accumulator array
package sfp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Extra headroom bits guarantee MAX_PASS full-scale psums never overflow.
    function automatic int acc_bw(input int psum_bw, input int max_pass);
        return psum_bw + clog2(max_pass);
    endfunction

    function automatic longint sat_max(input int bw);
        return (longint'(1) <<< (bw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int bw);
        return -(longint'(1) <<< (bw - 1));
    endfunction

endpackage

// File: rtl/sfp_acc_array_if.sv
// rtl/sfp_acc_array_if.sv - psum input stream and result output stream with valid/ready handshakes
interface sfp_acc_array_if #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [PSUM_BW*COL-1:0]   in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [PSUM_BW*COL-1:0]   out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/sfp_acc_array_post.sv
// rtl/sfp_acc_array_post.sv - per-column drain post-processing: optional round-shift (SFP_ROUND_SHIFT_EN), ReLU, saturation
module sfp_post
    import sfp_pkg::*;
#(
    parameter int ACC_BW  = 20,
    parameter int PSUM_BW = 16
) (
    input  logic [ACC_BW-1:0]  i_acc,
    input  logic               i_relu,
`ifdef SFP_ROUND_SHIFT_EN
    input  logic [3:0]         i_shift,
`endif
    output logic [PSUM_BW-1:0] o_res,
    output logic               o_sat
);
    // One spare bit so the rounding increment cannot wrap the accumulator value.
    localparam int VW = ACC_BW + 1;
    localparam logic signed [VW-1:0] MAXV = VW'(sat_max(PSUM_BW));
    localparam logic signed [VW-1:0] MINV = VW'(sat_min(PSUM_BW));

    logic signed [VW-1:0] w_val;
`ifdef SFP_ROUND_SHIFT_EN
    logic signed [VW-1:0] w_rnd;
`endif

    always_comb begin
        w_val = VW'($signed(i_acc));
`ifdef SFP_ROUND_SHIFT_EN
        w_rnd = '0;
        if (i_shift != 4'd0) begin
            w_rnd = VW'(1) << (i_shift - 4'd1);
            w_val = (w_val + w_rnd) >>> i_shift;
        end
`endif
        o_sat = 1'b0;
        o_res = w_val[PSUM_BW-1:0];
        if (i_relu && (w_val < 0)) begin
            o_res = '0;
        end else if (w_val > MAXV) begin
            o_res = MAXV[PSUM_BW-1:0];
            o_sat = 1'b1;
        end else if (w_val < MINV) begin
            o_res = MINV[PSUM_BW-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/sfp_acc_array.sv
// rtl/sfp_acc_array.sv - multi-entry multi-pass psum accumulator with flow-controlled drain; SFP_ROUND_SHIFT_EN adds cfg shift
module sfp_acc_array
    import sfp_pkg::*;
#(
    parameter int COL      = 8,
    parameter int PSUM_BW  = 16,
    parameter int DEPTH    = 16,
    parameter int MAX_PASS = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_cfg_start,
    input  logic [clog2(DEPTH):0]   i_cfg_nent,
    input  logic [clog2(MAX_PASS):0] i_cfg_npass,
    input  logic                    i_cfg_relu,
`ifdef SFP_ROUND_SHIFT_EN
    input  logic [3:0]              i_cfg_shift,
`endif
    sfp_acc_array_if.slave          s_if,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_sat_flag
);
    localparam int ACC_BW = acc_bw(PSUM_BW, MAX_PASS);
    localparam int EW     = clog2(DEPTH) + 1;
    localparam int PW     = clog2(MAX_PASS) + 1;
    localparam int AW     = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

    state_t                 r_state;
    logic [EW-1:0]          r_nent;
    logic [EW-1:0]          r_ent;
    logic [EW-1:0]          r_rd;
    logic [PW-1:0]          r_npass;
    logic [PW-1:0]          r_pass;
    logic                   r_relu;
    logic                   r_last;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [PSUM_BW*COL-1:0] r_out_data;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_sat;
`ifdef SFP_ROUND_SHIFT_EN
    logic [3:0]             r_shift;
`endif

    logic [COL*ACC_BW-1:0]  r_acc [DEPTH];

    logic [EW-1:0]          w_nent_cfg;
    logic [PW-1:0]          w_npass_cfg;
    logic [EW-1:0]          w_nent_m1;
    logic [PW-1:0]          w_npass_m1;
    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_load;
    logic [COL*ACC_BW-1:0]  w_acc_old;
    logic [COL*ACC_BW-1:0]  w_acc_new;
    logic [COL*ACC_BW-1:0]  w_acc_rd;
    logic [PSUM_BW*COL-1:0] w_post_data;
    logic [COL-1:0]         w_post_sat;

    always_comb begin
        w_nent_cfg = i_cfg_nent;
        if (i_cfg_nent == '0)
            w_nent_cfg = EW'(1);
        else if (i_cfg_nent > EW'(DEPTH))
            w_nent_cfg = EW'(DEPTH);
        w_npass_cfg = i_cfg_npass;
        if (i_cfg_npass == '0)
            w_npass_cfg = PW'(1);
        else if (i_cfg_npass > PW'(MAX_PASS))
            w_npass_cfg = PW'(MAX_PASS);
    end

    assign w_nent_m1  = r_nent - EW'(1);
    assign w_npass_m1 = r_npass - PW'(1);
    assign w_in_fire  = s_if.in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & s_if.out_ready;
    // The skid register refills whenever it is empty or being consumed this cycle.
    assign w_load     = (r_state == DRAIN) & (~r_out_valid | s_if.out_ready) & (r_rd != r_nent);
    assign w_acc_old  = r_acc[r_ent[AW-1:0]];
    assign w_acc_rd   = r_acc[r_rd[AW-1:0]];

    for (genvar i = 0; i < COL; i++) begin : g_col
        logic [ACC_BW-1:0] w_in_ext;

        assign w_in_ext = {{(ACC_BW-PSUM_BW){s_if.in_data[PSUM_BW*(i+1)-1]}},
                           s_if.in_data[PSUM_BW*i +: PSUM_BW]};
        assign w_acc_new[i*ACC_BW +: ACC_BW] = (r_pass == '0) ? w_in_ext
                                             : (w_acc_old[i*ACC_BW +: ACC_BW] + w_in_ext);

        sfp_post #(
            .ACC_BW  (ACC_BW),
            .PSUM_BW (PSUM_BW)
        ) u_post (
            .i_acc   (w_acc_rd[i*ACC_BW +: ACC_BW]),
            .i_relu  (r_relu),
`ifdef SFP_ROUND_SHIFT_EN
            .i_shift (r_shift),
`endif
            .o_res   (w_post_data[PSUM_BW*i +: PSUM_BW]),
            .o_sat   (w_post_sat[i])
        );
    end

    // Pass 0 overwrites, so entries need no reset and an aborted tile leaves no residue.
    always_ff @(posedge clk) begin
        if (w_in_fire)
            r_acc[r_ent[AW-1:0]] <= w_acc_new;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_nent      <= '0;
            r_ent       <= '0;
            r_rd        <= '0;
            r_npass     <= '0;
            r_pass      <= '0;
            r_relu      <= 1'b0;
            r_last      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sat       <= 1'b0;
`ifdef SFP_ROUND_SHIFT_EN
            r_shift     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_cfg_start) begin
                        r_nent     <= w_nent_cfg;
                        r_npass    <= w_npass_cfg;
                        r_relu     <= i_cfg_relu;
`ifdef SFP_ROUND_SHIFT_EN
                        r_shift    <= i_cfg_shift;
`endif
                        r_sat      <= 1'b0;
                        r_ent      <= '0;
                        r_pass     <= '0;
                        r_rd       <= '0;
                        r_last     <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ACC;
                    end
                end
                ACC: begin
                    if (w_in_fire) begin
                        if (r_ent == w_nent_m1) begin
                            r_ent <= '0;
                            if (r_pass == w_npass_m1) begin
                                r_in_ready <= 1'b0;
                                r_state    <= DRAIN;
                            end else begin
                                r_pass <= r_pass + PW'(1);
                            end
                        end else begin
                            r_ent <= r_ent + EW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_load) begin
                        r_out_data  <= w_post_data;
                        r_out_valid <= 1'b1;
                        r_rd        <= r_rd + EW'(1);
                        r_last      <= (r_rd == w_nent_m1);
                        if (|w_post_sat)
                            r_sat <= 1'b1;
                    end else if (s_if.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_out_fire && r_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_if.in_ready  = r_in_ready;
    assign s_if.out_valid = r_out_valid;
    assign s_if.out_data  = r_out_data;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_sat_flag     = r_sat;

endmodule
